// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: setup FSM states, packet size,
// vertex word layout and default screen geometry.
package gpu_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        DIFF,
        MUL,
        CULL,
        EMIT
    } setup_state_t;

    localparam int SETUP_WORDS = 9;

    localparam int VTX_X_LSB   = 16;
    localparam int VTX_Y_LSB   = 0;
    localparam int VTX_FIELD_W = 16;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    function automatic logic signed [15:0] vtx_x(input logic [31:0] v);
        return signed'(v[VTX_X_LSB +: VTX_FIELD_W]);
    endfunction

    function automatic logic signed [15:0] vtx_y(input logic [31:0] v);
        return signed'(v[VTX_Y_LSB +: VTX_FIELD_W]);
    endfunction

    function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [15:0] clamp_dim(input logic signed [15:0] v,
                                              input logic signed [15:0] last);
        if (v < 0)
            return '0;
        else if (v > last)
            return last;
        else
            return v;
    endfunction

endpackage

// File: rtl/tri_edge_coef.sv
// Edge function coefficients for one directed edge vi->vj:
// A = yi-yj, B = xj-xi, C = xi*yj - xj*yi.
module tri_edge_coef (
    input  logic signed [15:0] xi,
    input  logic signed [15:0] yi,
    input  logic signed [15:0] xj,
    input  logic signed [15:0] yj,
    output logic signed [15:0] a,
    output logic signed [15:0] b,
    output logic signed [31:0] c
);
    logic signed [31:0] xi_e, yi_e, xj_e, yj_e;

    // A/B only need 16 bits for vertices inside +-4095.
    assign a = yi - yj;
    assign b = xj - xi;

    // Low 32 bits of the full-width cross product are all the packet carries.
    assign xi_e = 32'(xi);
    assign yi_e = 32'(yi);
    assign xj_e = 32'(xj);
    assign yj_e = 32'(yj);
    assign c    = xi_e * yj_e - xj_e * yi_e;

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: gathers three vertices, computes bbox, edge coefficients and
// doubled area, culls, then streams a 9-word setup packet.
//   state   | meaning
//   COLLECT | accepting vertex words into v[cnt]
//   DIFF    | register vertex differences, edge A/B, raw min/max
//   MUL     | register area, edge C, clamped bbox, off-screen flag
//   CULL    | drop (count it) or start the packet
//   EMIT    | present word[idx] until word 8 transfers
module tri_setup
    import gpu_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int CULL_BACK = 1,
    parameter int CNT_W     = 16
) (
    input  logic             pll_clock,
    input  logic             sys_reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] culled_count,
    output logic             busy
);
    localparam logic signed [15:0] X_LAST   = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] Y_LAST   = 16'(SCREEN_H - 1);
    localparam logic [3:0]         LAST_IDX = 4'(SETUP_WORDS - 1);

    setup_state_t state, state_nxt;

    logic [31:0]        v [3];
    logic [1:0]         cnt;
    logic [3:0]         idx;
    logic signed [15:0] vx [3], vy [3];
    logic signed [15:0] ea [3], eb [3];
    logic signed [31:0] ec [3];

    logic signed [16:0] dx10, dy10, dx20, dy20;
    logic signed [33:0] dx10_e, dy10_e, dx20_e, dy20_e, area_nxt;
    logic signed [15:0] a_r [3], b_r [3];
    logic signed [15:0] xmin_raw, xmax_raw, ymin_raw, ymax_raw;
    logic signed [33:0] area;
    logic [31:0]        c_r [3];
    logic [15:0]        xmin, xmax, ymin, ymax;
    logic               off_screen, drop;

    for (genvar i = 0; i < 3; i++) begin : g_edge
        assign vx[i] = vtx_x(v[i]);
        assign vy[i] = vtx_y(v[i]);
        tri_edge_coef u_edge (
            .xi (vx[i]),
            .yi (vy[i]),
            .xj (vx[(i + 1) % 3]),
            .yj (vy[(i + 1) % 3]),
            .a  (ea[i]),
            .b  (eb[i]),
            .c  (ec[i])
        );
    end

    assign dx10_e   = 34'(dx10);
    assign dy10_e   = 34'(dy10);
    assign dx20_e   = 34'(dx20);
    assign dy20_e   = 34'(dy20);
    assign area_nxt = dx10_e * dy20_e - dx20_e * dy10_e;

    assign drop = (area == '0) || off_screen || ((CULL_BACK != 0) && area[33]);

    assign in_ready  = (state == COLLECT) && !sys_reset;
    assign out_valid = (state == EMIT);
    assign busy      = (state != COLLECT) || (cnt != 2'd0);

    always_ff @(posedge pll_clock) begin
        if (sys_reset)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (in_valid && in_ready && cnt == 2'd2) state_nxt = DIFF;
            DIFF:    state_nxt = MUL;
            MUL:     state_nxt = CULL;
            CULL:    state_nxt = drop ? COLLECT : EMIT;
            EMIT:    if (out_ready && idx == LAST_IDX) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge pll_clock) begin
        if (sys_reset) begin
            cnt          <= '0;
            idx          <= '0;
            culled_count <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        v[cnt] <= in_data;
                        cnt    <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
                    end
                end
                DIFF: begin
                    dx10     <= 17'(vx[1]) - 17'(vx[0]);
                    dy10     <= 17'(vy[1]) - 17'(vy[0]);
                    dx20     <= 17'(vx[2]) - 17'(vx[0]);
                    dy20     <= 17'(vy[2]) - 17'(vy[0]);
                    a_r      <= ea;
                    b_r      <= eb;
                    xmin_raw <= min3(vx[0], vx[1], vx[2]);
                    xmax_raw <= max3(vx[0], vx[1], vx[2]);
                    ymin_raw <= min3(vy[0], vy[1], vy[2]);
                    ymax_raw <= max3(vy[0], vy[1], vy[2]);
                end
                MUL: begin
                    area       <= area_nxt;
                    c_r[0]     <= ec[0];
                    c_r[1]     <= ec[1];
                    c_r[2]     <= ec[2];
                    xmin       <= clamp_dim(xmin_raw, X_LAST);
                    xmax       <= clamp_dim(xmax_raw, X_LAST);
                    ymin       <= clamp_dim(ymin_raw, Y_LAST);
                    ymax       <= clamp_dim(ymax_raw, Y_LAST);
                    off_screen <= (xmax_raw < 0) || (xmin_raw > X_LAST) ||
                                  (ymax_raw < 0) || (ymin_raw > Y_LAST);
                end
                CULL: begin
                    idx <= '0;
                    if (drop && culled_count != '1)
                        culled_count <= culled_count + CNT_W'(1);
                end
                EMIT: begin
                    if (out_ready)
                        idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        if (state == EMIT) begin
            case (idx)
                4'd0:    out_data = {xmin, ymin};
                4'd1:    out_data = {xmax, ymax};
                4'd2:    out_data = {a_r[0], b_r[0]};
                4'd3:    out_data = {a_r[1], b_r[1]};
                4'd4:    out_data = {a_r[2], b_r[2]};
                4'd5:    out_data = c_r[0];
                4'd6:    out_data = c_r[1];
                4'd7:    out_data = c_r[2];
                4'd8:    out_data = area[31:0];
                default: out_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_setup.sv
// Scoreboard bench for tri_setup: two instances (back-face culling on/off)
// share the same stimulus; each has its own expected-word queue and monitor.
module tb_tri_setup;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, busy0;
    logic [31:0] out_data0;
    logic [15:0] culled0;
    logic        in_ready1, out_valid1, busy1;
    logic [31:0] out_data1;
    logic [15:0] culled1;

    int checks = 0;
    int errors = 0;
    int pop_cnt0 = 0;
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    logic [31:0] pkt_ccw  [9] = '{32'h00000000, 32'h000A000A, 32'h0000000A, 32'hFFF6FFF6,
                                  32'h000A0000, 32'h00000000, 32'h00000064, 32'h00000000,
                                  32'h00000064};
    logic [31:0] pkt_back [9] = '{32'h00000000, 32'h000A000A, 32'hFFF60000, 32'h000A000A,
                                  32'h0000FFF6, 32'h00000000, 32'hFFFFFF9C, 32'h00000000,
                                  32'hFFFFFF9C};
    logic [31:0] pkt_clmp [9] = '{32'h00000005, 32'h027F01DF, 32'h000002D0, 32'hFE11FDA8,
                                  32'h01EFFF88, 32'hFFFFF1F0, 32'h0005553C, 32'h00002904,
                                  32'h00057030};

    always #5 clk = ~clk;

    tri_setup #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACK(1), .CNT_W(16)) u_dut0 (
        .pll_clock(clk), .sys_reset(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready), .culled_count(culled0), .busy(busy0));

    tri_setup #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACK(0), .CNT_W(16)) u_dut1 (
        .pll_clock(clk), .sys_reset(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .culled_count(culled1), .busy(busy1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs only change at posedge+1, so a word seen valid&&ready here transfers next edge.
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected word: got 0x%08h, expected none", out_data0);
            end else
                check("dut0 word", out_data0, exp_q0.pop_front());
            pop_cnt0++;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready) begin
            if (exp_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected word: got 0x%08h, expected none", out_data1);
            end else
                check("dut1 word", out_data1, exp_q1.pop_front());
        end
    end

    task automatic push_pkt(input bit to0, input bit to1, input logic [31:0] p [9]);
        for (int i = 0; i < 9; i++) begin
            if (to0) exp_q0.push_back(p[i]);
            if (to1) exp_q1.push_back(p[i]);
        end
    endtask

    task automatic send_vtx(input int x, input int y);
        int n = 0;
        while (!(in_ready0 && in_ready1) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("in_ready timeout", 32'(in_ready0 && in_ready1), 32'd1);
        in_valid = 1'b1;
        in_data  = {x[15:0], y[15:0]};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
        send_vtx(x0, y0);
        send_vtx(x1, y1);
        send_vtx(x2, y2);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("drain timeout", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pop_cnt0 != target && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("word wait timeout", 32'(pop_cnt0), 32'(target));
    endtask

    initial begin
        int c;
        int base;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("reset in_ready", 32'(in_ready0), 32'd0);
        check("reset out_valid", 32'(out_valid0), 32'd0);
        check("reset out_data", out_data0, 32'd0);
        check("reset culled", 32'(culled0), 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 32'(in_ready0), 32'd1);

        // CCW triangle, W0 latency
        push_pkt(1, 1, pkt_ccw);
        send_tri(0, 0, 10, 0, 0, 10);
        c = 0;
        while (!out_valid0 && c < 20) begin @(posedge clk); #1; c++; end
        check("w0 latency", 32'(c), 32'd3);
        drain();
        check("ccw culled", 32'(culled0), 32'd0);

        // Collinear: culled, in_ready returns after 3 cycles
        send_tri(5, 5, 10, 10, 15, 15);
        check("collinear busy", 32'(busy0), 32'd1);
        c = 0;
        while (!in_ready0 && c < 20) begin @(posedge clk); #1; c++; end
        check("collinear ready latency", 32'(c), 32'd3);
        check("collinear culled0", 32'(culled0), 32'd1);
        check("collinear culled1", 32'(culled1), 32'd1);
        check("collinear out_valid", 32'(out_valid0), 32'd0);

        // Back-face: dropped by dut0, emitted by dut1
        push_pkt(0, 1, pkt_back);
        send_tri(0, 0, 0, 10, 10, 0);
        drain();
        check("backface culled0", 32'(culled0), 32'd2);
        check("backface culled1", 32'(culled1), 32'd1);

        // Screen clamping
        push_pkt(1, 1, pkt_clmp);
        send_tri(-20, 5, 700, 5, 100, 500);
        drain();

        // Fully off-screen
        send_tri(-50, -50, -10, -50, -10, -10);
        c = 0;
        while (!(in_ready0 && in_ready1) && c < 20) begin @(posedge clk); #1; c++; end
        check("offscreen culled0", 32'(culled0), 32'd3);
        check("offscreen culled1", 32'(culled1), 32'd2);

        // Backpressure while W3 is presented
        base = pop_cnt0;
        push_pkt(1, 1, pkt_ccw);
        send_tri(0, 0, 10, 0, 0, 10);
        wait_pops(base + 3);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall out_data", out_data0, 32'hFFF6FFF6);
            check("stall out_valid", 32'(out_valid0), 32'd1);
            check("stall in_ready", 32'(in_ready0), 32'd0);
        end
        out_ready = 1'b1;
        drain();

        // Reset while W4 is presented
        base = pop_cnt0;
        push_pkt(1, 1, pkt_ccw);
        send_tri(0, 0, 10, 0, 0, 10);
        wait_pops(base + 4);
        check("pre-reset W4", out_data0, 32'h000A0000);
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid0), 32'd0);
        check("midreset culled0", 32'(culled0), 32'd0);
        check("midreset culled1", 32'(culled1), 32'd0);
        check("midreset busy", 32'(busy0), 32'd0);
        check("midreset in_ready", 32'(in_ready0), 32'd1);
        exp_q0.delete();
        exp_q1.delete();
        out_ready = 1'b1;

        // Clean triangle after reset
        push_pkt(1, 1, pkt_ccw);
        send_tri(0, 0, 10, 0, 0, 10);
        drain();
        repeat (3) begin @(posedge clk); #1; end
        check("final culled0", 32'(culled0), 32'd0);
        check("final queue0", 32'(exp_q0.size()), 32'd0);
        check("final queue1", 32'(exp_q1.size()), 32'd0);
        check("final out_valid", 32'(out_valid0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
